// File: rtl/vector_slice_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vector_slice_stream_ctrl                                                 |
// | Loads a vector register, then streams its scalars out one per handshake. |
// | Optional: VECTOR_SLICE_STREAM_CTRL_OVERLAP_EN (back-to-back vectors).    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module vector_slice_stream_ctrl #(
    parameter  int SCALAR_BITS = 32,
    parameter  int LENGTH      = 5,
    localparam int INDEX_WIDTH = $clog2(LENGTH),
    localparam int COUNT_WIDTH = $clog2(LENGTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [COUNT_WIDTH-1:0] in_count,
    output logic                   vec_load,
    output logic [INDEX_WIDTH-1:0] vec_read_index,
    input  logic [SCALAR_BITS-1:0] vec_slice,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SCALAR_BITS-1:0] out_data,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last,
    output logic                   busy
);

    localparam logic [0:0]             C_ST_IDLE    = 1'b0;
    localparam logic [0:0]             C_ST_STREAM  = 1'b1;
    localparam logic [COUNT_WIDTH-1:0] C_LENGTH_CNT = COUNT_WIDTH'(LENGTH);
    localparam logic [INDEX_WIDTH-1:0] C_LAST_MAX   = INDEX_WIDTH'(LENGTH - 1);

    logic [0:0]             r_state;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [INDEX_WIDTH-1:0] r_last_idx;

    logic [0:0]             w_state_nxt;
    logic [INDEX_WIDTH-1:0] w_idx_nxt;
    logic [INDEX_WIDTH-1:0] w_last_idx_nxt;

    logic                   w_accept;
    logic                   w_handshake;
    logic                   w_at_last;
    logic [COUNT_WIDTH-1:0] w_eff_count;
    logic [INDEX_WIDTH-1:0] w_new_last_idx;

    // A zero or oversized count means "the whole vector".
    assign w_eff_count    = ((in_count == '0) || (in_count > C_LENGTH_CNT)) ? C_LENGTH_CNT : in_count;
    assign w_new_last_idx = INDEX_WIDTH'(w_eff_count - COUNT_WIDTH'(1));

    assign w_at_last   = (r_idx == r_last_idx);
    assign w_accept    = in_valid & in_ready;
    assign w_handshake = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= C_ST_IDLE;
            r_idx      <= '0;
            r_last_idx <= C_LAST_MAX;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_last_idx <= w_last_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_last_idx_nxt = r_last_idx;
        case (r_state)
            C_ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt    = C_ST_STREAM;
                    w_idx_nxt      = '0;
                    w_last_idx_nxt = w_new_last_idx;
                end
            end
            C_ST_STREAM: begin
                if (w_handshake) begin
                    if (!w_at_last) begin
                        w_idx_nxt = r_idx + INDEX_WIDTH'(1);
                    end else if (w_accept) begin
                        // Overlapped accept: the register reloads on this same edge.
                        w_idx_nxt      = '0;
                        w_last_idx_nxt = w_new_last_idx;
                    end else begin
                        w_state_nxt = C_ST_IDLE;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = C_ST_IDLE;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b0;
        if (r_state == C_ST_STREAM) begin
            out_valid = 1'b1;
            out_last  = w_at_last;
            busy      = 1'b1;
`ifdef VECTOR_SLICE_STREAM_CTRL_OVERLAP_EN
            in_ready  = w_at_last & out_ready;
`else
            in_ready  = 1'b0;
`endif
        end
    end

    assign vec_load       = w_accept;
    assign vec_read_index = r_idx;
    assign out_index      = r_idx;
    assign out_data       = vec_slice;

endmodule
`default_nettype wire

// File: tb/tb_vector_slice_stream_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vector_slice_stream_ctrl                                              |
// | Self-checking bench with a vector-register model and expected-stream ref.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_vector_slice_stream_ctrl;

    localparam int SB  = 32;
    localparam int LEN = 5;

    typedef logic [SB-1:0] vec_t [8];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2:0]    in_count = '0;
    logic          vec_load;
    logic [2:0]    vec_read_index;
    logic [SB-1:0] vec_slice;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [SB-1:0] out_data;
    logic [2:0]    out_index;
    logic          out_last;
    logic          busy;

    vec_t          vin;
    vec_t          mem;

    int n_cmp  = 0;
    int n_fail = 0;

    vector_slice_stream_ctrl #(.SCALAR_BITS(SB), .LENGTH(LEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_count(in_count), .vec_load(vec_load), .vec_read_index(vec_read_index),
        .vec_slice(vec_slice), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    // Vector register: parallel load, combinational slice read.
    always @(posedge clk) begin
        if (vec_load) begin
            for (int i = 0; i < 8; i++) mem[i] <= vin[i];
        end
    end
    assign vec_slice = mem[vec_read_index];

    function automatic int eff_len(input int cnt);
        return (cnt == 0 || cnt > LEN) ? LEN : cnt;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = $urandom;
        return v;
    endfunction

    // Called right after a rising edge with the DUT idle. mode: 0 always ready,
    // 1 ready alternating 1,0,1,..., 2 random ready.
    task automatic stream_vector(input vec_t v, input int cnt, input int mode);
        int n, k, cyc;
        logic exp_ir;
        n = eff_len(cnt);
        in_valid = 1'b1; in_count = 3'(cnt); vin = v; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || vec_load !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accept: in_ready=%b vec_load=%b out_valid=%b, required 1 1 0", in_ready, vec_load, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0; cyc = 0;
        while (k < n && cyc < 100) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
`ifdef VECTOR_SLICE_STREAM_CTRL_OVERLAP_EN
            exp_ir = (k == n - 1) && out_ready;
`else
            exp_ir = 1'b0;
`endif
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== v[k] || out_index !== 3'(k) ||
                out_last !== (k == n - 1) || vec_load !== 1'b0 || in_ready !== exp_ir || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL stream k=%0d n=%0d: valid=%b data=%h idx=%0d last=%b load=%b ir=%b busy=%b, required 1 %h %0d %b 0 %b 1",
                         k, n, out_valid, out_data, out_index, out_last, vec_load, in_ready, busy,
                         v[k], k, (k == n - 1), exp_ir);
            end
            @(posedge clk); #1;
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b0;
        if (k < n) begin
            n_cmp++; n_fail++;
            $display("FAIL stream_timeout: got %0d of %0d scalars", k, n);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_idle: busy=%b valid=%b in_ready=%b, required 0 0 1", busy, out_valid, in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 ||
            vec_load !== 1'b0 || vec_read_index !== 3'd0) begin
            n_fail++;
            $display("FAIL reset: ir=%b valid=%b last=%b busy=%b load=%b ridx=%0d, required 1 0 0 0 0 0",
                     in_ready, out_valid, out_last, busy, vec_load, vec_read_index);
        end
        in_valid = 1'b1;
        #1;
        n_cmp++;
        if (vec_load !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_load: vec_load=%b, required 1", vec_load);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: busy=%b valid=%b, required 0 0", busy, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_full_vector();
        vec_t v;
        for (int i = 0; i < 8; i++) v[i] = SB'(i * 'h11);
        stream_vector(v, 0, 0);
        stream_vector(rand_vec(), 5, 0);
    endtask

    task automatic test_backpressure();
        stream_vector(rand_vec(), 3, 1);
        for (int t = 0; t < 4; t++) stream_vector(rand_vec(), int'($urandom_range(0, 7)), 2);
    endtask

    task automatic test_counts();
        stream_vector(rand_vec(), 1, 0);
        stream_vector(rand_vec(), 7, 0);
        stream_vector(rand_vec(), 6, 2);
        for (int t = 0; t < 6; t++) stream_vector(rand_vec(), int'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
    endtask

`ifndef VECTOR_SLICE_STREAM_CTRL_OVERLAP_EN
    task automatic test_hold_in_valid();
        vec_t v1, v2;
        int c2;
        v1 = rand_vec(); v2 = rand_vec(); c2 = int'($urandom_range(1, 5));
        in_valid = 1'b1; in_count = 3'd5; vin = v1; out_ready = 1'b1;
        @(posedge clk); #1;
        vin = v2; in_count = 3'(c2);
        for (int k = 0; k < LEN; k++) begin
            @(negedge clk);
            n_cmp++;
            if (in_ready !== 1'b0 || vec_load !== 1'b0 || out_data !== v1[k] || out_index !== 3'(k)) begin
                n_fail++;
                $display("FAIL hold_in_valid k=%0d: ir=%b load=%b data=%h idx=%0d, required 0 0 %h %0d",
                         k, in_ready, vec_load, out_data, out_index, v1[k], k);
            end
            @(posedge clk); #1;
        end
        stream_vector(v2, c2, 0);
    endtask
`else
    task automatic test_back_to_back();
        vec_t v1, v2;
        v1 = rand_vec(); v2 = rand_vec();
        in_valid = 1'b1; in_count = 3'd0; vin = v1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int j = 0; j < 2 * LEN; j++) begin
            int k;
            logic [SB-1:0] exp_d;
            k = j % LEN;
            exp_d = (j < LEN) ? v1[k] : v2[k];
            if (j == LEN - 1) begin
                in_valid = 1'b1; vin = v2; in_count = 3'd5;
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp_d || out_index !== 3'(k) || out_last !== (k == LEN - 1) ||
                vec_load !== (j == LEN - 1) || in_ready !== (k == LEN - 1)) begin
                n_fail++;
                $display("FAIL back_to_back j=%0d: valid=%b data=%h idx=%0d last=%b load=%b ir=%b, required 1 %h %0d %b %b %b",
                         j, out_valid, out_data, out_index, out_last, vec_load, in_ready,
                         exp_d, k, (k == LEN - 1), (j == LEN - 1), (k == LEN - 1));
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
        out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_idle: busy=%b, required 0", busy);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_mid_reset();
        vec_t v;
        v = rand_vec();
        in_valid = 1'b1; in_count = 3'd5; vin = v; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        n_cmp++;
        if (out_index !== 3'd2 || out_data !== v[2]) begin
            n_fail++;
            $display("FAIL mid_reset_pre: idx=%0d data=%h, required 2 %h", out_index, out_data, v[2]);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_index !== 3'd0) begin
            n_fail++;
            $display("FAIL mid_reset: valid=%b busy=%b ir=%b idx=%0d, required 0 0 1 0", out_valid, busy, in_ready, out_index);
        end
        @(posedge clk); #1;
        stream_vector(rand_vec(), int'($urandom_range(0, 7)), 2);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin vin[i] = '0; end
        test_reset();
        test_full_vector();
        test_backpressure();
        test_counts();
`ifndef VECTOR_SLICE_STREAM_CTRL_OVERLAP_EN
        test_hold_in_valid();
`else
        test_back_to_back();
`endif
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
